// File: rtl/lab3_cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lab3_cache_mem_arbiter_if (package + interface)
// Description : 4-byte memory request/response message types and the
//               val/rdy request/response bundle used by caches and memory.
// Revision    : 1.0 - initial release
// ============================================================================

package lab3_cache_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

interface lab3_cache_mem_arbiter_if;
    import lab3_cache_mem_arbiter_pkg::*;

    logic         req_val;
    logic         req_rdy;
    mem_req_4B_t  req_msg;
    logic         resp_val;
    logic         resp_rdy;
    mem_resp_4B_t resp_msg;

    // Requester side (cache, or the arbiter facing memory)
    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    // Responder side (memory, or the arbiter facing a cache)
    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

`default_nettype wire

// File: rtl/lab3_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lab3_cache_mem_arbiter
// Description : Shares one memory port between icache (port0) and dcache
//               (port1). Round-robin grant with a lock that holds the grant
//               until memory accepts; an in-order port-ID queue steers
//               responses back to their owner.
//               Optional macro LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN selects
//               fixed priority (port0 wins ties) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================

module lab3_cache_mem_arbiter #(
    parameter int p_num_outstanding = 4
) (
    input  wire logic                clk,
    input  wire logic                reset,
    lab3_cache_mem_arbiter_if.slave  port0,
    lab3_cache_mem_arbiter_if.slave  port1,
    lab3_cache_mem_arbiter_if.master mem
);

    localparam int c_ptr_w = (p_num_outstanding > 1) ? $clog2(p_num_outstanding) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_cnt_full = (c_ptr_w + 1)'(p_num_outstanding);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t                  r_state;
    lock_state_t                  w_state_nxt;
    logic                         r_lock_id;
    logic                         w_lock_id_nxt;
    logic [p_num_outstanding-1:0] r_queue;
    logic [c_ptr_w-1:0]           r_head;
    logic [c_ptr_w-1:0]           r_tail;
    logic [c_ptr_w:0]             r_count;

    logic w_tie_id;
    logic w_full;
    logic w_empty;
    logic w_gnt_any;
    logic w_gnt_id;
    logic w_req_val;
    logic w_push;
    logic w_head_id;
    logic w_resp_rdy;
    logic w_pop;

`ifdef LAB3_CACHE_MEM_ARBITER_FIXED_PRIO_EN
    assign w_tie_id = 1'b0;
`else
    logic r_prio;

    // Favour the port that did not win the most recent transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'b0;
        end else if (w_push) begin
            r_prio <= ~w_gnt_id;
        end
    end

    assign w_tie_id = r_prio;
`endif

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);

    // Grant selection: lock wins, then tie-break, then single requester
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = r_lock_id;
        end else if (port0.req_val && port1.req_val) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = w_tie_id;
        end else if (port0.req_val) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = 1'b0;
        end else if (port1.req_val) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = 1'b1;
        end
        // A full queue (or reset) blocks every grant
        if (w_full || !reset) begin
            w_gnt_any = 1'b0;
        end
    end

    assign w_req_val     = w_gnt_any & (w_gnt_id ? port1.req_val : port0.req_val);
    assign w_push        = w_req_val & mem.req_rdy;
    assign mem.req_val   = w_req_val;
    assign mem.req_msg   = w_gnt_id ? port1.req_msg : port0.req_msg;
    assign port0.req_rdy = w_gnt_any & ~w_gnt_id & mem.req_rdy;
    assign port1.req_rdy = w_gnt_any &  w_gnt_id & mem.req_rdy;

    // Response steering by the queue head; nothing routed when empty
    assign w_head_id      = r_queue[r_head];
    assign w_resp_rdy     = reset & ~w_empty & (w_head_id ? port1.resp_rdy : port0.resp_rdy);
    assign w_pop          = mem.resp_val & w_resp_rdy;
    assign mem.resp_rdy   = w_resp_rdy;
    assign port0.resp_val = reset & ~w_empty & ~w_head_id & mem.resp_val;
    assign port1.resp_val = reset & ~w_empty &  w_head_id & mem.resp_val;
    assign port0.resp_msg = mem.resp_msg;
    assign port1.resp_msg = mem.resp_msg;

    // Lock state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_OPEN;
            r_lock_id <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // Lock next-state: latch the grant when memory stalls a valid request
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        case (r_state)
            ST_OPEN: begin
                if (w_req_val && !mem.req_rdy) begin
                    w_state_nxt   = ST_LOCKED;
                    w_lock_id_nxt = w_gnt_id;
                end
            end
            ST_LOCKED: begin
                if (w_push) begin
                    w_state_nxt = ST_OPEN;
                end
            end
            default: w_state_nxt = ST_OPEN;
        endcase
    end

    // In-order port-ID tracking queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_queue <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_queue[r_tail] <= w_gnt_id;
                r_tail          <= r_tail + c_ptr_one;
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lab3_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab3_cache_mem_arbiter
// Description : Directed table-driven bench for the cache/memory arbiter,
//               plus an asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_lab3_cache_mem_arbiter;
    import lab3_cache_mem_arbiter_pkg::*;

    logic clk;
    logic reset;

    lab3_cache_mem_arbiter_if p0 ();
    lab3_cache_mem_arbiter_if p1 ();
    lab3_cache_mem_arbiter_if mem ();

    lab3_cache_mem_arbiter #(.p_num_outstanding(4)) dut (
        .clk   (clk),
        .reset (reset),
        .port0 (p0.slave),
        .port1 (p1.slave),
        .mem   (mem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_bits : {p0_req_val, p1_req_val, mem_req_rdy, mem_resp_val, p0_resp_rdy, p1_resp_rdy}
    // exp_bits: {mem_req_val, grant_id, p0_req_rdy, p1_req_rdy, mem_resp_rdy, p0_resp_val, p1_resp_val}
    typedef struct packed {
        logic [5:0]  in_bits;
        logic [31:0] rdata;
        logic [6:0]  exp_bits;
    } vec_t;

    mem_req_4B_t c_msg0;
    mem_req_4B_t c_msg1;
    vec_t        vecs [16];
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        p0.req_val   = 1'b0;
        p1.req_val   = 1'b0;
        mem.req_rdy  = 1'b0;
        mem.resp_val = 1'b0;
        p0.resp_rdy  = 1'b0;
        p1.resp_rdy  = 1'b0;
        mem.resp_msg = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req_val"},  128'(mem.req_val),  128'(0));
        check({tag, ".p0_req_rdy"},   128'(p0.req_rdy),   128'(0));
        check({tag, ".p1_req_rdy"},   128'(p1.req_rdy),   128'(0));
        check({tag, ".mem_resp_rdy"}, 128'(mem.resp_rdy), 128'(0));
        check({tag, ".p0_resp_val"},  128'(p0.resp_val),  128'(0));
        check({tag, ".p1_resp_val"},  128'(p1.resp_val),  128'(0));
    endtask

    // Drive one cycle's inputs, let them settle, then compare
    task automatic apply(input vec_t v, input string tag);
        mem_req_4B_t exp_msg;
        {p0.req_val, p1.req_val, mem.req_rdy, mem.resp_val, p0.resp_rdy, p1.resp_rdy} = v.in_bits;
        mem.resp_msg      = '0;
        mem.resp_msg.data = v.rdata;
        #1;
        check({tag, ".mem_req_val"}, 128'(mem.req_val), 128'(v.exp_bits[6]));
        if (v.exp_bits[6]) begin
            exp_msg = v.exp_bits[5] ? c_msg1 : c_msg0;
            check({tag, ".mem_req_msg"}, 128'(mem.req_msg), 128'(exp_msg));
        end
        check({tag, ".p0_req_rdy"},   128'(p0.req_rdy),   128'(v.exp_bits[4]));
        check({tag, ".p1_req_rdy"},   128'(p1.req_rdy),   128'(v.exp_bits[3]));
        check({tag, ".mem_resp_rdy"}, 128'(mem.resp_rdy), 128'(v.exp_bits[2]));
        check({tag, ".p0_resp_val"},  128'(p0.resp_val),  128'(v.exp_bits[1]));
        check({tag, ".p1_resp_val"},  128'(p1.resp_val),  128'(v.exp_bits[0]));
        if (v.exp_bits[1]) check({tag, ".p0_resp_data"}, 128'(p0.resp_msg.data), 128'(v.rdata));
        if (v.exp_bits[0]) check({tag, ".p1_resp_data"}, 128'(p1.resp_msg.data), 128'(v.rdata));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        c_msg0 = '{msg_type: 3'd0, opaque: 8'h5A, addr: 32'h0000_0100, len: 2'd0, data: 32'h0};
        c_msg1 = '{msg_type: 3'd1, opaque: 8'hA5, addr: 32'h0000_0200, len: 2'd0, data: 32'h1234_5678};
        p0.req_msg = c_msg0;
        p1.req_msg = c_msg1;

        // Single port request, then its response back on port0 only
        vecs[0]  = '{6'b101_011, 32'h0000_0000, 7'b1010_000};
        vecs[1]  = '{6'b000_111, 32'hCAFE_F00D, 7'b0000_110};
        // Contention: prio now favours port1
        vecs[2]  = '{6'b111_011, 32'h0000_0000, 7'b1101_000};
        vecs[3]  = '{6'b111_011, 32'h0000_0000, 7'b1010_100};
        // Lock on port1 for three stalled cycles, responses drain meanwhile
        vecs[4]  = '{6'b110_111, 32'h1111_1111, 7'b1100_101};
        vecs[5]  = '{6'b110_101, 32'h2222_2222, 7'b1100_010};
        vecs[6]  = '{6'b110_111, 32'h2222_2222, 7'b1100_110};
        vecs[7]  = '{6'b111_011, 32'h0000_0000, 7'b1101_000};
        vecs[8]  = '{6'b111_011, 32'h0000_0000, 7'b1010_100};
        // Lock on port0 overrides prio favouring port1
        vecs[9]  = '{6'b100_000, 32'h0000_0000, 7'b1000_000};
        vecs[10] = '{6'b111_000, 32'h0000_0000, 7'b1010_000};
        // Fill the queue, full blocks grant, one pop reopens it
        vecs[11] = '{6'b111_000, 32'h0000_0000, 7'b1101_000};
        vecs[12] = '{6'b111_101, 32'h3333_3333, 7'b0000_101};
        vecs[13] = '{6'b111_110, 32'h4444_4444, 7'b1010_110};
        vecs[14] = '{6'b000_111, 32'h5555_5555, 7'b0000_110};
        vecs[15] = '{6'b000_111, 32'h6666_6666, 7'b0000_101};

        // Reset asserted with busy inputs: every val/rdy output is held low
        reset = 1'b0;
        drive_idle();
        p0.req_val   = 1'b1;
        mem.req_rdy  = 1'b1;
        mem.resp_val = 1'b1;
        p0.resp_rdy  = 1'b1;
        p1.resp_rdy  = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Mid-burst asynchronous reset between clock edges (queue holds one entry)
        {p0.req_val, p1.req_val, mem.req_rdy, mem.resp_val, p0.resp_rdy, p1.resp_rdy} = 6'b111_111;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        // Queue empty after reset, port0 wins the first tie
        apply('{6'b111_111, 32'h7777_7777, 7'b1010_000}, "post_reset0");
        @(negedge clk);
        apply('{6'b111_111, 32'h8888_8888, 7'b1101_110}, "post_reset1");
        @(negedge clk);
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
